// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a controller (master) and the serial subtractor (slave).
interface serial_subtractor_if #(parameter int WIDTH = 8);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );

endinterface

// File: rtl/serial_subtractor_onebit.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module onebitsubtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b - bin processed LSB first through one shared cell.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  sub
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             cell_d;
    logic             cell_bo;

    onebitsubtractor u_cell (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a new request directly so back-to-back ops have no bubble.
                if (sub.start) begin
                    a_sr_d  = sub.a;
                    b_sr_d  = sub.b;
                    brw_d   = sub.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {cell_d, res_q[WIDTH-1:1]};
                brw_d  = cell_bo;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // Results publish on the final bit so they stay stable throughout BUSY.
                    diff_d  = {cell_d, res_q[WIDTH-1:1]};
                    bout_d  = cell_bo;
                    ovf_d   = brw_q ^ cell_bo;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sub.busy = (state_q == S_BUSY);
    assign sub.done = (state_q == S_DONE);
    assign sub.diff = diff_q;
    assign sub.bout = bout_q;
    assign sub.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor and its one-bit cell.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) sub_if ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .sub (sub_if)
    );

    logic cx, cy, cb, cd, cbo;

    onebitsubtractor u_cell_chk (
        .x    (cx),
        .y    (cy),
        .bin  (cb),
        .d    (cd),
        .bout (cbo)
    );

    typedef struct {
        logic [2:0] xyb;
        logic       d;
        logic       bo;
    } cell_vec_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } op_vec_t;

    cell_vec_t cell_tab[8];
    op_vec_t   op_tab[9];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        sub_if.start = 1'b1;
        sub_if.a     = a;
        sub_if.b     = b;
        sub_if.bin   = bin;
    endtask

    // Caller is at a negedge with start driven; returns cycles until done and busy cycle count.
    // While busy, diff must keep the previously published value.
    task automatic wait_done(input logic [W-1:0] hold, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                sub_if.start = 1'b0;
                sub_if.a     = W'($urandom);
                sub_if.b     = W'($urandom);
                sub_if.bin   = 1'($urandom);
            end
            if (sub_if.busy) begin
                bcnt++;
                if (k == 4) chk("diff_hold_busy", 32'(sub_if.diff), 32'(hold));
            end
            if (sub_if.done) begin
                cyc = k;
                break;
            end
        end
        if (cyc == 0) begin
            errors++;
            checks++;
            $display("FAIL done_timeout: no done within 20 cycles");
        end
    endtask

    int cyc, bcnt, seen_done;
    logic [W-1:0] last_diff;

    initial begin
        $display("time  done diff bout ovf");
        $monitor("%0t  %b %h %b %b", $time, sub_if.done, sub_if.diff, sub_if.bout, sub_if.ovf);

        cell_tab[0] = '{3'b000, 1'b0, 1'b0};
        cell_tab[1] = '{3'b001, 1'b1, 1'b1};
        cell_tab[2] = '{3'b010, 1'b1, 1'b1};
        cell_tab[3] = '{3'b011, 1'b0, 1'b1};
        cell_tab[4] = '{3'b100, 1'b1, 1'b0};
        cell_tab[5] = '{3'b101, 1'b0, 1'b0};
        cell_tab[6] = '{3'b110, 1'b0, 1'b0};
        cell_tab[7] = '{3'b111, 1'b1, 1'b1};

        op_tab[0] = '{8'd100, 8'd58,  1'b0, 8'd42,  1'b0, 1'b0};
        op_tab[1] = '{8'd5,   8'd7,   1'b0, 8'hFE,  1'b1, 1'b0};
        op_tab[2] = '{8'h80,  8'h01,  1'b0, 8'h7F,  1'b0, 1'b1};
        op_tab[3] = '{8'h00,  8'h00,  1'b1, 8'hFF,  1'b1, 1'b0};
        op_tab[4] = '{8'h7F,  8'hFF,  1'b0, 8'h80,  1'b1, 1'b1};
        op_tab[5] = '{8'hFF,  8'hFF,  1'b1, 8'hFF,  1'b1, 1'b0};
        op_tab[6] = '{8'h50,  8'h30,  1'b1, 8'h1F,  1'b0, 1'b0};
        op_tab[7] = '{8'h00,  8'h80,  1'b0, 8'h80,  1'b1, 1'b1};
        op_tab[8] = '{8'hAA,  8'h55,  1'b0, 8'h55,  1'b0, 1'b1};

        sub_if.start = 1'b0;
        sub_if.a     = '0;
        sub_if.b     = '0;
        sub_if.bin   = 1'b0;
        cx = 1'b0; cy = 1'b0; cb = 1'b0;

        for (int i = 0; i < 8; i++) begin
            {cx, cy, cb} = cell_tab[i].xyb;
            #1;
            chk($sformatf("cell_d_%0d", i), 32'(cd), 32'(cell_tab[i].d));
            chk($sformatf("cell_bo_%0d", i), 32'(cbo), 32'(cell_tab[i].bo));
        end

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(sub_if.busy), 32'd0);
        chk("rst_done", 32'(sub_if.done), 32'd0);
        chk("rst_diff", 32'(sub_if.diff), 32'd0);
        chk("rst_bout", 32'(sub_if.bout), 32'd0);
        chk("rst_ovf",  32'(sub_if.ovf),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        last_diff = '0;
        for (int i = 0; i < 9; i++) begin
            launch(op_tab[i].a, op_tab[i].b, op_tab[i].bin);
            wait_done(last_diff, cyc, bcnt);
            chk($sformatf("lat_%0d", i),  32'(cyc),  32'd9);
            chk($sformatf("busy_%0d", i), 32'(bcnt), 32'd8);
            chk($sformatf("diff_%0d", i), 32'(sub_if.diff), 32'(op_tab[i].diff));
            chk($sformatf("bout_%0d", i), 32'(sub_if.bout), 32'(op_tab[i].bout));
            chk($sformatf("ovf_%0d", i),  32'(sub_if.ovf),  32'(op_tab[i].ovf));
            last_diff = op_tab[i].diff;
            @(negedge clk);
            chk($sformatf("done_pulse_%0d", i), 32'(sub_if.done), 32'd0);
            chk($sformatf("diff_hold_%0d", i), 32'(sub_if.diff), 32'(op_tab[i].diff));
        end

        // Back-to-back: restart in the done cycle.
        launch(8'd100, 8'd58, 1'b0);
        wait_done(last_diff, cyc, bcnt);
        chk("b2b_first_diff", 32'(sub_if.diff), 32'd42);
        launch(8'd5, 8'd7, 1'b0);
        wait_done(8'd42, cyc, bcnt);
        chk("b2b_lat", 32'(cyc), 32'd9);
        chk("b2b_busy", 32'(bcnt), 32'd8);
        chk("b2b_diff", 32'(sub_if.diff), 32'hFE);
        chk("b2b_bout", 32'(sub_if.bout), 32'd1);
        @(negedge clk);

        // Start while busy is ignored.
        launch(8'd100, 8'd58, 1'b0);
        cyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            sub_if.start = 1'b0;
            if (k == 3) launch(8'h80, 8'h01, 1'b1);
            if (sub_if.done) begin
                cyc = k;
                break;
            end
        end
        chk("ign_lat", 32'(cyc), 32'd9);
        chk("ign_diff", 32'(sub_if.diff), 32'd42);
        chk("ign_bout", 32'(sub_if.bout), 32'd0);
        chk("ign_ovf",  32'(sub_if.ovf),  32'd0);
        @(negedge clk);

        // Make outputs nonzero, then abort an operation with reset.
        launch(8'h80, 8'h01, 1'b0);
        wait_done(8'd42, cyc, bcnt);
        chk("pre_rst_ovf", 32'(sub_if.ovf), 32'd1);
        @(negedge clk);
        launch(8'd5, 8'd7, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            sub_if.start = 1'b0;
        end
        chk("pre_rst_busy", 32'(sub_if.busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(sub_if.busy), 32'd0);
        chk("abort_done", 32'(sub_if.done), 32'd0);
        chk("abort_diff", 32'(sub_if.diff), 32'd0);
        chk("abort_bout", 32'(sub_if.bout), 32'd0);
        chk("abort_ovf",  32'(sub_if.ovf),  32'd0);
        seen_done = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (sub_if.done || sub_if.busy) seen_done++;
        end
        chk("abort_quiet", 32'(seen_done), 32'd0);

        $monitoroff;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
